// File: rtl/matmul_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | matmul_pkg : shared types and sizes for the matmul engine feeder   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package matmul_pkg;

    localparam int unsigned LANE_W = 8;
    localparam int unsigned LANES  = 5;
    localparam int unsigned WORD_W = LANE_W * LANES;
    localparam int unsigned DEF_N  = 5;
    localparam int unsigned DEF_T  = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SEND_W,
        S_SEND_IN,
        S_WAIT_RES,
        S_FINISH
    } state_t;

    // Index width that stays at least one bit for single-entry buffers.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_feeder_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | matmul_feeder_buf : word buffer, one write port, one registered    |
// | read port that returns zero when disabled or out of range. Rev 1.0 |
// +--------------------------------------------------------------------+
module matmul_feeder_buf
    import matmul_pkg::*;
#(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned WIDTH = 40,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    localparam int unsigned IW = addr_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem[wr_addr[IW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en && (32'(rd_addr) < DEPTH)) begin
            rd_data <= mem[rd_addr[IW-1:0]];
        end else begin
            rd_data <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/matmul_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | matmul_feeder : loads weights/inputs into the matmul engine and    |
// | collects its results into a host-readable buffer. Rev 1.0          |
// +--------------------------------------------------------------------+
module matmul_feeder
    import matmul_pkg::*;
#(
    parameter  int unsigned N       = DEF_N,
    parameter  int unsigned T       = DEF_T,
    parameter  int unsigned R       = 1,
    parameter  int unsigned TIMEOUT = 64,
    localparam int unsigned AW      = addr_w((N > T) ? N : T),
    localparam int unsigned RA_W    = addr_w(R)
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              go,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    input  logic [RA_W-1:0]   rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_ov,
    output logic              start_o,
    output logic [WORD_W-1:0] Weight_o,
    output logic [WORD_W-1:0] In_o,
    input  logic [WORD_W-1:0] OUT_i,
    input  logic              VAL_i,
    input  logic              OV_i
);

    localparam int unsigned RCW = $clog2(R + 1);
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);

    state_t          state, state_nxt;
    logic [AW-1:0]   cnt, cnt_nxt;
    logic [TW-1:0]   wcnt, wcnt_nxt;
    logic [RCW-1:0]  rcnt, rcnt_nxt;
    logic            timeout_hit;
    logic            w_rd_en, i_rd_en, res_we;
    logic [AW-1:0]   w_rd_addr, i_rd_addr;
    logic [WORD_W:0] res_word;

    // Buffer read addresses lead the phase by one cycle so the registered
    // read port lines the word up with the state that presents it.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        wcnt_nxt    = wcnt;
        rcnt_nxt    = rcnt;
        timeout_hit = 1'b0;
        w_rd_en     = 1'b0;
        w_rd_addr   = '0;
        i_rd_en     = 1'b0;
        i_rd_addr   = '0;
        res_we      = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    state_nxt = S_START;
                    cnt_nxt   = '0;
                    wcnt_nxt  = '0;
                    rcnt_nxt  = '0;
                end
            end
            S_START: begin
                state_nxt = S_SEND_W;
                cnt_nxt   = '0;
                w_rd_en   = 1'b1;
            end
            S_SEND_W: begin
                if (cnt == AW'(N - 1)) begin
                    state_nxt = S_SEND_IN;
                    cnt_nxt   = '0;
                    i_rd_en   = 1'b1;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                    w_rd_en   = 1'b1;
                    w_rd_addr = cnt + 1'b1;
                end
            end
            S_SEND_IN: begin
                if (cnt == AW'(T - 1)) begin
                    state_nxt = S_WAIT_RES;
                    cnt_nxt   = '0;
                    wcnt_nxt  = '0;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                    i_rd_en   = 1'b1;
                    i_rd_addr = cnt + 1'b1;
                end
            end
            S_WAIT_RES: begin
                wcnt_nxt = wcnt + 1'b1;
                res_we   = VAL_i;
                if (VAL_i) begin
                    rcnt_nxt = rcnt + 1'b1;
                end
                // A final result in the timeout cycle still counts as success.
                if (VAL_i && (rcnt == RCW'(R - 1))) begin
                    state_nxt = S_FINISH;
                end else if (wcnt == TW'(TIMEOUT - 1)) begin
                    state_nxt   = S_FINISH;
                    timeout_hit = 1'b1;
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state       <= S_IDLE;
            cnt         <= '0;
            wcnt        <= '0;
            rcnt        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            start_o     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            wcnt    <= wcnt_nxt;
            rcnt    <= rcnt_nxt;
            busy    <= (state_nxt != S_IDLE);
            done    <= (state_nxt == S_FINISH);
            start_o <= (state_nxt == S_START);
            if ((state == S_IDLE) && go) begin
                err_timeout <= 1'b0;
            end else if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end

    matmul_feeder_buf #(.DEPTH(N), .WIDTH(WORD_W), .AW(AW)) u_wbuf (
        .clk     (CLK),
        .rst_n   (RSTN),
        .wr_en   (wr_en && !wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (w_rd_en),
        .rd_addr (w_rd_addr),
        .rd_data (Weight_o)
    );

    matmul_feeder_buf #(.DEPTH(T), .WIDTH(WORD_W), .AW(AW)) u_ibuf (
        .clk     (CLK),
        .rst_n   (RSTN),
        .wr_en   (wr_en && wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (i_rd_en),
        .rd_addr (i_rd_addr),
        .rd_data (In_o)
    );

    matmul_feeder_buf #(.DEPTH(R), .WIDTH(WORD_W + 1), .AW(RCW)) u_rbuf (
        .clk     (CLK),
        .rst_n   (RSTN),
        .wr_en   (res_we),
        .wr_addr (rcnt),
        .wr_data ({OV_i, OUT_i}),
        .rd_en   (1'b1),
        .rd_addr (RCW'(rd_addr)),
        .rd_data (res_word)
    );

    assign rd_ov   = res_word[WORD_W];
    assign rd_data = res_word[WORD_W-1:0];

endmodule
`default_nettype wire
